proc_fetch_unit: RTL and testbench

Instruction-fetch front end of the five-stage TinyRV1 pipeline, sitting directly upstream of the decode stage. Owns the fetch PC, issues in-order requests to instruction memory over a val/rdy interface, buffers returned instructions in a small queue, and presents them to D with their PC. Accepts redirects for jr, jal and taken bne. On a redirect it discards the queue and all in-flight wrong-path responses.

---
 rtl/proc_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_proc_fetch_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/proc_fetch_unit.sv
// proc_fetch_unit: instruction-fetch front end of the TinyRV1 pipeline.
//
// Owns the fetch PC and issues in-order requests to instruction memory over val/rdy.
// Returned instructions are buffered in a DEPTH-entry queue and presented to decode
// together with their PC. A redirect (jr, jal, taken bne) reloads the PC, empties the
// queue and marks every outstanding memory response as stale so it is discarded.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   imemreq_val_o/rdy_i    fetch request handshake; imemreq_addr_o is the PC register
//   imemresp_val_i/data_i  in-order responses, never back-pressured
//   redirect_val_i/pc_i    redirect from control; pc[1:0] ignored
//   inst_val_o/rdy_i       instruction handshake towards decode
//   inst_o, inst_pc_o      instruction at the queue head and its PC
//
// Optional feature: define FETCH_RESP_BYPASS_EN to let a response go straight to decode
// when the queue is empty and nothing is pending discard.
module proc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0200,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imemreq_val_o,
  input  logic        imemreq_rdy_i,
  output logic [31:0] imemreq_addr_o,
  input  logic        imemresp_val_i,
  input  logic [31:0] imemresp_data_i,
  input  logic        redirect_val_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_val_o,
  input  logic        inst_rdy_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [31:0]     pc_q, pc_d;
  logic [31:0]     q_inst_q [DEPTH];
  logic [31:0]     q_pc_q   [DEPTH];
  logic [PtrW-1:0] q_head_q, q_head_d, q_tail_q, q_tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] inflight_q, inflight_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic [31:0]     rpc_q [DEPTH];
  logic [PtrW-1:0] rpc_head_q, rpc_head_d, rpc_tail_q, rpc_tail_d;

  logic            req_fire, deq, enq, byp_active, byp_taken;
  logic [CntW:0]   occupancy;
  logic [31:0]     resp_pc;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign resp_pc   = rpc_q[rpc_head_q];
  assign occupancy = {1'b0, count_q} + {1'b0, inflight_q};

`ifdef FETCH_RESP_BYPASS_EN
  assign byp_active = rst_ni & imemresp_val_i & (count_q == '0) & (drop_q == '0);
`else
  assign byp_active = 1'b0;
`endif

  always_comb begin
    // Gated by rst_ni so both valids are low while the block is held in reset.
    imemreq_val_o  = rst_ni & ~redirect_val_i & (occupancy < (CntW + 1)'(DEPTH));
    imemreq_addr_o = pc_q;
    inst_val_o     = rst_ni & ~redirect_val_i & ((count_q != '0) | byp_active);
    inst_o         = byp_active ? imemresp_data_i : q_inst_q[q_head_q];
    inst_pc_o      = byp_active ? resp_pc         : q_pc_q[q_head_q];

    req_fire  = imemreq_val_o & imemreq_rdy_i;
    byp_taken = inst_val_o & inst_rdy_i & byp_active;
    deq       = inst_val_o & inst_rdy_i & ~byp_active;
    enq       = imemresp_val_i & (drop_q == '0) & ~redirect_val_i & ~byp_taken;
  end

  always_comb begin
    pc_d       = pc_q;
    q_head_d   = q_head_q;
    q_tail_d   = q_tail_q;
    count_d    = count_q;
    inflight_d = inflight_q + CntW'(req_fire) - CntW'(imemresp_val_i);
    drop_d     = drop_q;
    rpc_head_d = imemresp_val_i ? ptr_inc(rpc_head_q) : rpc_head_q;
    rpc_tail_d = req_fire ? ptr_inc(rpc_tail_q) : rpc_tail_q;

    if (redirect_val_i) begin
      pc_d     = {redirect_pc_i[31:2], 2'b00};
      q_head_d = '0;
      q_tail_d = '0;
      count_d  = '0;
      // Every outstanding request is wrong-path now. Stale ones already counted in
      // drop are also counted in inflight, so the new drop total is just inflight,
      // less the response (always discarded) arriving this cycle.
      drop_d   = inflight_q - CntW'(imemresp_val_i);
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      if (deq) q_head_d = ptr_inc(q_head_q);
      if (enq) q_tail_d = ptr_inc(q_tail_q);
      count_d = count_q + CntW'(enq) - CntW'(deq);
      if (imemresp_val_i && (drop_q != '0)) drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q       <= RESET_PC;
      q_head_q   <= '0;
      q_tail_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      rpc_head_q <= '0;
      rpc_tail_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_inst_q[i] <= '0;
        q_pc_q[i]   <= '0;
        rpc_q[i]    <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      q_head_q   <= q_head_d;
      q_tail_q   <= q_tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      rpc_head_q <= rpc_head_d;
      rpc_tail_q <= rpc_tail_d;
      if (enq) begin
        q_inst_q[q_tail_q] <= imemresp_data_i;
        q_pc_q[q_tail_q]   <= resp_pc;
      end
      if (req_fire) rpc_q[rpc_tail_q] <= pc_q;
    end
  end

endmodule

// File: tb/tb_proc_fetch_unit.sv
// Testbench for proc_fetch_unit: randomized memory latency, stalls and redirects,
// checked each cycle against a program-order reference model.
module tb_proc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0200;
  localparam int unsigned DEPTH    = 2;
`ifdef FETCH_RESP_BYPASS_EN
  localparam int FirstLat = 1;
`else
  localparam int FirstLat = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        imemreq_val, imemreq_rdy;
  logic [31:0] imemreq_addr;
  logic        imemresp_val;
  logic [31:0] imemresp_data;
  logic        redirect_val;
  logic [31:0] redirect_pc;
  logic        inst_val, inst_rdy;
  logic [31:0] inst, inst_pc;

  always #5 clk = ~clk;

  proc_fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .imemreq_val_o   (imemreq_val),
    .imemreq_rdy_i   (imemreq_rdy),
    .imemreq_addr_o  (imemreq_addr),
    .imemresp_val_i  (imemresp_val),
    .imemresp_data_i (imemresp_data),
    .redirect_val_i  (redirect_val),
    .redirect_pc_i   (redirect_pc),
    .inst_val_o      (inst_val),
    .inst_rdy_i      (inst_rdy),
    .inst_o          (inst),
    .inst_pc_o       (inst_pc)
  );

  // Memory model: each accepted request remembers its cycle, address and the
  // redirect epoch it was issued in; a response from an older epoch is wrong-path.
  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] addr;
    logic [31:0] epoch;
  } mreq_t;

  mreq_t       memq[$];
  int unsigned cyc, epoch, qcount;
  logic [31:0] exp_req_pc, exp_pc;
  int          checks, failures;
  int unsigned first_req_cyc, first_iv_cyc;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    memq.delete();
    qcount     = 0;
    epoch      = 0;
    cyc        = 0;
    exp_req_pc = RESET_PC;
    exp_pc     = RESET_PC;
  endtask

  // One clock cycle: entered just after a rising edge, drives inputs, compares at the
  // falling edge, advances the model to match the next rising edge.
  task automatic cycle(input int p_rdy, input int p_resp, input int p_redir, input int p_irdy);
    logic  head_live, exp_rv, exp_iv, byp;
    mreq_t e;
    cyc++;
    imemreq_rdy   = ($urandom_range(99) < p_rdy);
    imemresp_val  = 1'b0;
    imemresp_data = '0;
    head_live     = 1'b0;
    if (memq.size() > 0 && memq[0].cyc < cyc && $urandom_range(99) < p_resp) begin
      imemresp_val  = 1'b1;
      imemresp_data = mdata(memq[0].addr);
      head_live     = (memq[0].epoch == epoch);
    end
    redirect_val = ($urandom_range(99) < p_redir);
    redirect_pc  = $urandom;
    inst_rdy     = ($urandom_range(99) < p_irdy);
    #4;
    byp = 1'b0;
`ifdef FETCH_RESP_BYPASS_EN
    byp = head_live && (qcount == 0);
`endif
    exp_rv = !redirect_val && (qcount + memq.size() < DEPTH);
    exp_iv = !redirect_val && (qcount > 0 || byp);
    chk("imemreq_val", {31'd0, imemreq_val}, {31'd0, exp_rv});
    chk("imemreq_addr", imemreq_addr, exp_req_pc);
    chk("inst_val", {31'd0, inst_val}, {31'd0, exp_iv});
    if (exp_iv) begin
      chk("inst_pc", inst_pc, exp_pc);
      chk("inst", inst, mdata(exp_pc));
    end
    if (first_req_cyc == 0 && imemreq_val && imemreq_rdy) first_req_cyc = cyc;
    if (first_iv_cyc == 0 && inst_val) first_iv_cyc = cyc;

    if (imemresp_val) begin
      e = memq.pop_front();
      if (!redirect_val && e.epoch == epoch) qcount++;
    end
    if (exp_iv && inst_rdy) begin
      qcount--;
      exp_pc += 32'd4;
    end
    if (exp_rv && imemreq_rdy) begin
      memq.push_back('{cyc: cyc, addr: exp_req_pc, epoch: epoch});
      exp_req_pc += 32'd4;
    end
    if (redirect_val) begin
      epoch++;
      qcount     = 0;
      exp_req_pc = {redirect_pc[31:2], 2'b00};
      exp_pc     = {redirect_pc[31:2], 2'b00};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_imemreq_val"}, {31'd0, imemreq_val}, 32'd0);
    chk({tag, "_inst_val"}, {31'd0, inst_val}, 32'd0);
    chk({tag, "_imemreq_addr"}, imemreq_addr, RESET_PC);
    chk({tag, "_inst"}, inst, 32'd0);
    chk({tag, "_inst_pc"}, inst_pc, 32'd0);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    first_req_cyc = 0;
    first_iv_cyc  = 0;
    rst_ni        = 1'b0;
    imemreq_rdy   = 1'b0;
    imemresp_val  = 1'b0;
    imemresp_data = '0;
    redirect_val  = 1'b0;
    redirect_pc   = '0;
    inst_rdy      = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("reset");

    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    // Ideal memory (always ready, latency 1), decode always ready.
    repeat (20) cycle(100, 100, 0, 100);
    chk("first_inst_latency", first_iv_cyc - first_req_cyc, FirstLat);

    // Decode stalled: fetch must throttle, then resume without loss.
    repeat (8) cycle(100, 100, 0, 0);
    repeat (10) cycle(100, 100, 0, 100);

    // Memory stalls, variable latency, occasional redirects.
    repeat (1500) cycle(70, 60, 5, 70);

    // Frequent redirects so they land on outstanding requests.
    repeat (500) cycle(90, 40, 20, 80);

    // Reset asserted mid-stream; outputs must drop without waiting for a clock.
    repeat (3) cycle(100, 0, 0, 0);
    rst_ni       = 1'b0;
    imemresp_val = 1'b0;
    redirect_val = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    first_req_cyc = 0;
    first_iv_cyc  = 0;
    rst_ni = 1'b1;
    repeat (20) cycle(100, 100, 0, 100);
    chk("restart_latency", first_iv_cyc - first_req_cyc, FirstLat);
    repeat (1000) cycle(75, 65, 4, 75);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
